// File: rtl/q_frag_ctrl_pkg.sv
// rtl/q_frag_ctrl_pkg.sv - shared state encoding and counter sizing for q_frag_ctrl
package q_frag_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RST   = 2'd1,
    SET   = 2'd2,
    RECOV = 2'd3
  } state_e;

  // One counter serves both the pulse and the recovery phase.
  function automatic int cnt_width(input int pulse, input int recov);
    int longest;
    longest = (pulse > recov) ? pulse : recov;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/q_sync.sv
// rtl/q_sync.sv - generic N-stage level synchronizer with async active-low clear
module q_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/q_frag_ctrl.sv
// rtl/q_frag_ctrl.sv - set/reset pulse sequencer and load port for the flop fragment
// Optional request synchronizers: define Q_FRAG_CTRL_SYNC_EN.
module q_frag_ctrl
  import q_frag_ctrl_pkg::*;
#(
  parameter int PULSE_CYCLES   = 2,
  parameter int RECOVER_CYCLES = 1,
  parameter int SYNC_STAGES    = 2
) (
  input  logic QCK,
  input  logic QRTN,
  input  logic RST_REQ,
  input  logic SET_REQ,
  input  logic LD_VLD,
  input  logic LD_DAT,
  output logic LD_RDY,
  output logic QRT,
  output logic QST,
  output logic QEN,
  output logic QDI,
  output logic CDS,
  output logic BUSY,
  output logic CONFLICT
);

  localparam int CW = cnt_width(PULSE_CYCLES, RECOVER_CYCLES);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] RECOV_LOAD = CW'(RECOVER_CYCLES);

  if (PULSE_CYCLES < 1 || RECOVER_CYCLES < 0 || SYNC_STAGES < 2) begin : g_bad_params
    $error("q_frag_ctrl: illegal parameter value");
  end

  logic rst_lvl;
  logic set_lvl;

`ifdef Q_FRAG_CTRL_SYNC_EN
  q_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (
    .clk   (QCK),
    .rst_n (QRTN),
    .d     (RST_REQ),
    .q     (rst_lvl)
  );

  q_sync #(.STAGES(SYNC_STAGES)) u_sync_set (
    .clk   (QCK),
    .rst_n (QRTN),
    .d     (SET_REQ),
    .q     (set_lvl)
  );
`else
  assign rst_lvl = RST_REQ;
  assign set_lvl = SET_REQ;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_rst_q, pend_rst_d;
  logic            pend_set_q, pend_set_d;
  logic            rst_prev_q, set_prev_q;
  logic            conflict_q, conflict_d;
  logic            qrt_q, qrt_d;
  logic            qst_q, qst_d;
  logic            qen_q, qen_d;
  logic            qdi_q, qdi_d;
  logic            ld_rdy_q, ld_rdy_d;
  logic            busy_q, busy_d;
  logic            cds_q;
  logic            rst_rise;
  logic            set_rise;
  logic            handshake;

  assign rst_rise  = rst_lvl & ~rst_prev_q;
  assign set_rise  = set_lvl & ~set_prev_q;
  assign handshake = LD_VLD & ld_rdy_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_rst_d = pend_rst_q;
    pend_set_d = pend_set_q;
    conflict_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_rst_q) begin
          state_d    = RST;
          cnt_d      = PULSE_LOAD;
          pend_rst_d = 1'b0;
          if (pend_set_q) begin
            pend_set_d = 1'b0;
            conflict_d = 1'b1;
          end
        end else if (pend_set_q) begin
          state_d    = SET;
          cnt_d      = PULSE_LOAD;
          pend_set_d = 1'b0;
        end
      end
      RST, SET: begin
        if (cnt_q == CW'(1)) begin
          if (RECOVER_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = RECOV;
            cnt_d   = RECOV_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RECOV: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A repeat edge of the pulse already running (or just starting) is absorbed by it.
    if (rst_rise && state_q != RST && state_d != RST) begin
      pend_rst_d = 1'b1;
    end
    if (set_rise && state_q != SET && state_d != SET) begin
      pend_set_d = 1'b1;
    end

    qrt_d    = (state_d == RST);
    qst_d    = (state_d == SET);
    busy_d   = (state_d != IDLE);
    ld_rdy_d = (state_d == IDLE) && !pend_rst_d && !pend_set_d;
    qen_d    = handshake;
    qdi_d    = handshake ? LD_DAT : qdi_q;
  end

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      state_q    <= RST;
      cnt_q      <= PULSE_LOAD;
      pend_rst_q <= 1'b0;
      pend_set_q <= 1'b0;
      rst_prev_q <= 1'b0;
      set_prev_q <= 1'b0;
      conflict_q <= 1'b0;
      qrt_q      <= 1'b1;
      qst_q      <= 1'b0;
      qen_q      <= 1'b0;
      qdi_q      <= 1'b0;
      ld_rdy_q   <= 1'b0;
      busy_q     <= 1'b1;
      cds_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_rst_q <= pend_rst_d;
      pend_set_q <= pend_set_d;
      rst_prev_q <= rst_lvl;
      set_prev_q <= set_lvl;
      conflict_q <= conflict_d;
      qrt_q      <= qrt_d;
      qst_q      <= qst_d;
      qen_q      <= qen_d;
      qdi_q      <= qdi_d;
      ld_rdy_q   <= ld_rdy_d;
      busy_q     <= busy_d;
      cds_q      <= 1'b1;
    end
  end

  assign LD_RDY   = ld_rdy_q;
  assign QRT      = qrt_q;
  assign QST      = qst_q;
  assign QEN      = qen_q;
  assign QDI      = qdi_q;
  assign CDS      = cds_q;
  assign BUSY     = busy_q;
  assign CONFLICT = conflict_q;

endmodule
